// File: rtl/lcd_spi_arbiter_if.sv
// lcd_spi_arbiter_if: requester and spi_master byte-handshake signals of the LCD arbiter
interface lcd_spi_arbiter_if #(parameter int NREQ = 3);
    logic [NREQ-1:0]   req;
    logic [7*NREQ-1:0] x_pos;
    logic [3*NREQ-1:0] y_pos;
    logic [9*NREQ-1:0] len;
    logic [8*NREQ-1:0] data;
    logic [NREQ-1:0]   data_valid;
    logic [NREQ-1:0]   data_ack;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic              init_done;
    logic [7:0]        spi_data;
    logic              spi_command;
    logic              spi_start;
    logic              spi_avail;

    modport master (
        input  req, x_pos, y_pos, len, data, data_valid, spi_avail,
        output data_ack, grant, done, init_done, spi_data, spi_command, spi_start
    );

    modport slave (
        output req, x_pos, y_pos, len, data, data_valid, spi_avail,
        input  data_ack, grant, done, init_done, spi_data, spi_command, spi_start
    );
endinterface

// File: rtl/lcd_spi_arbiter.sv
// lcd_spi_arbiter: PCD8544 init/clear, then round-robin drawing bursts onto the shared spi_master
module lcd_spi_arbiter #(
    parameter int         NREQ      = 3,
    parameter logic [7:0] VOP_CMD   = 8'h90,
    parameter int         LCD_BYTES = 504
) (
    input logic               clock,
    input logic               Reset,
    lcd_spi_arbiter_if.master bus
);
    typedef enum logic [2:0] {S_INIT, S_CLEAR, S_IDLE, S_ADDR_X, S_ADDR_Y, S_DATA, S_FINISH} state_t;

    localparam logic [8:0] CLEAR_LAST = 9'(LCD_BYTES + 1);
    localparam logic [8:0] MAX_LEN    = 9'(LCD_BYTES);

    state_t          state, state_nx;
    logic [8:0]      cnt, cnt_nx;
    logic [1:0]      ptr, ptr_nx, win, cand;
    logic            run, init_done_q, hit;
    logic            start, cmd, ack;
    logic [7:0]      byte_o, init_byte;
    logic [6:0]      x_k;
    logic [2:0]      y_k;
    logic [8:0]      len_k, burst_len;
    logic [7:0]      data_k;
    logic            cur_req, valid_k;
    logic [NREQ-1:0] onehot;

    assign x_k       = bus.x_pos[7*ptr +: 7];
    assign y_k       = bus.y_pos[3*ptr +: 3];
    assign len_k     = bus.len[9*ptr +: 9];
    assign data_k    = bus.data[8*ptr +: 8];
    assign cur_req   = bus.req[ptr];
    assign valid_k   = bus.data_valid[ptr];
    assign onehot    = NREQ'(1) << ptr;
    assign burst_len = len_k > MAX_LEN ? MAX_LEN : len_k;
    assign init_byte = cnt[1:0] == 2'd0 ? 8'h21 :
                       cnt[1:0] == 2'd1 ? VOP_CMD :
                       cnt[1:0] == 2'd2 ? 8'h20 : 8'h0C;

    // Descending scan so the nearest requester after ptr is the last one written
    always_comb begin
        hit  = 1'b0;
        win  = ptr;
        cand = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = 2'((int'(ptr) + i) % NREQ);
            if (bus.req[cand]) begin
                hit = 1'b1;
                win = cand;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ptr_nx   = ptr;
        start    = 1'b0;
        cmd      = 1'b0;
        ack      = 1'b0;
        byte_o   = 8'h00;
        case (state)
            S_INIT: begin
                start  = run;
                byte_o = run ? init_byte : 8'h00;
                if (run && bus.spi_avail) begin
                    cnt_nx   = cnt == 9'd3 ? 9'd0 : cnt + 9'd1;
                    state_nx = cnt == 9'd3 ? S_CLEAR : S_INIT;
                end
            end
            S_CLEAR: begin
                start  = 1'b1;
                cmd    = cnt > 9'd1;
                byte_o = cnt == 9'd0 ? 8'h80 : cnt == 9'd1 ? 8'h40 : 8'h00;
                if (bus.spi_avail) begin
                    cnt_nx   = cnt == CLEAR_LAST ? 9'd0 : cnt + 9'd1;
                    state_nx = cnt == CLEAR_LAST ? S_IDLE : S_CLEAR;
                end
            end
            S_IDLE: begin
                if (hit) begin
                    ptr_nx   = win;
                    state_nx = S_ADDR_X;
                end
            end
            S_ADDR_X: begin
                start  = 1'b1;
                byte_o = 8'h80 | {1'b0, x_k};
                if (!cur_req) state_nx = S_IDLE;
                else if (bus.spi_avail) state_nx = S_ADDR_Y;
            end
            S_ADDR_Y: begin
                start  = 1'b1;
                byte_o = 8'h40 | {5'b0, y_k};
                cnt_nx = burst_len;
                if (!cur_req) state_nx = S_IDLE;
                else if (bus.spi_avail) state_nx = burst_len == 9'd0 ? S_FINISH : S_DATA;
            end
            S_DATA: begin
                start  = valid_k;
                cmd    = 1'b1;
                byte_o = data_k;
                ack    = valid_k && bus.spi_avail;
                if (ack) cnt_nx = cnt - 9'd1;
                if (!cur_req) state_nx = S_IDLE;
                else if (ack && cnt == 9'd1) state_nx = S_FINISH;
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_INIT;
        endcase
    end

    // run holds the bus quiet during the reset cycle even though state is already S_INIT
    always_ff @(posedge clock) begin
        if (!Reset) begin
            state       <= S_INIT;
            cnt         <= 9'd0;
            ptr         <= 2'(NREQ - 1);
            run         <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            ptr         <= ptr_nx;
            run         <= 1'b1;
            init_done_q <= init_done_q | (state == S_CLEAR && state_nx == S_IDLE);
        end
    end

    assign bus.spi_start   = start;
    assign bus.spi_data    = byte_o;
    assign bus.spi_command = cmd;
    assign bus.init_done   = init_done_q;
    assign bus.grant       = (state inside {S_ADDR_X, S_ADDR_Y, S_DATA, S_FINISH}) ? onehot : '0;
    assign bus.done        = state == S_FINISH ? onehot : '0;
    assign bus.data_ack    = ack ? onehot : '0;
endmodule

// File: tb/tb_lcd_spi_arbiter.sv
// tb_lcd_spi_arbiter: table-driven bursts plus directed init, round-robin, stall, abort and reset sequences
module tb_lcd_spi_arbiter;
    localparam int NREQ = 3;

    typedef struct {
        int         r;
        logic [6:0] x;
        logic [2:0] y;
        logic [8:0] len;
        logic [7:0] base;
        logic       tog;
        logic [7:0] ex;
        logic [7:0] ey;
        int         nd;
    } vec_t;

    logic        clock = 1'b0;
    logic        Reset = 1'b0;
    logic        tog   = 1'b0;
    logic [31:0] cyc   = 0;
    logic [7:0]  base_r [NREQ];
    logic [7:0]  idx    [NREQ];

    logic [8:0] sent[$];
    int         gq[$];
    int         ack_cnt  [NREQ];
    int         done_cnt [NREQ];
    int         bad_pre = 0;
    int         bad_gap = 0;
    logic [NREQ-1:0] last_g = '0;

    int nvec = 0;
    int nmis = 0;

    always #5 clock = ~clock;

    lcd_spi_arbiter_if #(.NREQ(NREQ)) bus();
    lcd_spi_arbiter #(.NREQ(NREQ)) dut (.clock(clock), .Reset(Reset), .bus(bus));

    assign bus.spi_avail = !tog | cyc[0];

    // Requester data source: each requester advances its byte on data_ack
    always @(posedge clock) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NREQ; i++)
            if (!Reset) idx[i] <= 8'h00;
            else if (bus.data_ack[i]) idx[i] <= idx[i] + 8'h01;
    end

    always_comb begin
        bus.data = '0;
        for (int i = 0; i < NREQ; i++) bus.data[8*i +: 8] = base_r[i] + idx[i];
    end

    always @(negedge clock) begin
        if (bus.spi_start === 1'b1 && bus.spi_avail === 1'b1)
            sent.push_back({bus.spi_command, bus.spi_data});
        for (int i = 0; i < NREQ; i++) begin
            if (bus.data_ack[i] === 1'b1) ack_cnt[i]++;
            if (bus.done[i] === 1'b1) done_cnt[i]++;
        end
        if (Reset === 1'b1) begin
            if (bus.grant != 0 && !bus.init_done) bad_pre++;
            if (bus.grant != 0 && last_g == 0)
                for (int i = 0; i < NREQ; i++) if (bus.grant[i]) gq.push_back(i);
            if (bus.grant != 0 && last_g != 0 && bus.grant != last_g) bad_gap++;
            last_g = bus.grant;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [19:0] outs();
        return {bus.spi_start, bus.spi_data, bus.spi_command, bus.grant, bus.data_ack, bus.done, bus.init_done};
    endfunction

    task automatic run_burst(input vec_t v);
        int s0, a0, d0, k, bad;
        logic [7:0] i0;
        logic [8:0] exp;
        @(posedge clock); #1;
        s0 = sent.size(); a0 = ack_cnt[v.r]; d0 = done_cnt[v.r]; i0 = idx[v.r];
        bus.x_pos[7*v.r +: 7] = v.x;
        bus.y_pos[3*v.r +: 3] = v.y;
        bus.len[9*v.r +: 9]   = v.len;
        base_r[v.r]           = v.base;
        tog                   = v.tog;
        bus.data_valid        = '1;
        bus.req[v.r]          = 1'b1;
        @(negedge clock); check("grant_before_latency", bus.grant, 0);
        @(negedge clock); check("grant_latency", bus.grant, 1 << v.r);
        for (k = 0; k < 2000; k++) begin
            if (bus.done[v.r]) break;
            @(negedge clock);
        end
        check("burst_done_seen", k < 2000, 1);
        @(posedge clock); #1;
        bus.req[v.r] = 1'b0;
        tog = 1'b0;
        @(negedge clock); check("grant_cleared", bus.grant, 0);
        check("burst_nbytes", sent.size() - s0, 2 + v.nd);
        check("set_x_cmd", sent[s0], {1'b0, v.ex});
        check("set_y_cmd", sent[s0+1], {1'b0, v.ey});
        bad = 0;
        for (int j = 0; j < v.nd; j++) begin
            exp = {1'b1, v.base + i0 + 8'(j)};
            if (sent[s0+2+j] !== exp) bad++;
        end
        check("data_bytes_bad", bad, 0);
        check("data_acks", ack_cnt[v.r] - a0, v.nd);
        check("done_pulses", done_cnt[v.r] - d0, 1);
    endtask

    vec_t vecs[6];

    initial begin
        int k, n, s0, s1, a0, d0, st, bad, g0;
        int dd[NREQ];
        logic [7:0] i0;
        logic [8:0] exp;
        vecs[0] = '{1, 7'd5,   3'd2, 9'd3,   8'hA1, 1'b0, 8'h85, 8'h42, 3};
        vecs[1] = '{0, 7'd0,   3'd5, 9'd0,   8'h00, 1'b0, 8'h80, 8'h45, 0};
        vecs[2] = '{1, 7'd1,   3'd1, 9'd510, 8'h00, 1'b0, 8'h81, 8'h41, 504};
        vecs[3] = '{0, 7'd127, 3'd7, 9'd1,   8'h55, 1'b0, 8'hFF, 8'h47, 1};
        vecs[4] = '{2, 7'd40,  3'd0, 9'd5,   8'hF0, 1'b1, 8'hA8, 8'h40, 5};
        vecs[5] = '{2, 7'd83,  3'd3, 9'd2,   8'h10, 1'b0, 8'hD3, 8'h43, 2};
        bus.req = '0; bus.data_valid = '0;
        bus.x_pos = '0; bus.y_pos = '0; bus.len = '0;
        for (int i = 0; i < NREQ; i++) base_r[i] = 8'h00;

        // Reset, init command sequence and display clear
        repeat (3) @(negedge clock);
        check("reset_outputs", outs(), 0);
        @(posedge clock); #1 Reset = 1'b1;
        for (k = 0; k < 3000; k++) begin
            @(negedge clock);
            if (bus.init_done) break;
        end
        check("init_done_rise", bus.init_done, 1);
        check("init_byte_count", sent.size(), 510);
        check("init_0", sent[0], 9'h021);
        check("init_1", sent[1], 9'h090);
        check("init_2", sent[2], 9'h020);
        check("init_3", sent[3], 9'h00C);
        check("clear_x", sent[4], 9'h080);
        check("clear_y", sent[5], 9'h040);
        n = 0;
        for (int j = 6; j < 510; j++) if (sent[j] === 9'h100) n++;
        check("clear_zero_bytes", n, 504);

        foreach (vecs[i]) run_burst(vecs[i]);

        // Round robin with all three requesting, one byte each
        @(posedge clock); #1;
        g0 = gq.size();
        for (int i = 0; i < NREQ; i++) dd[i] = done_cnt[i];
        for (int i = 0; i < NREQ; i++) bus.len[9*i +: 9] = 9'd1;
        bus.data_valid = '1;
        bus.req = '1;
        n = 0;
        for (k = 0; k < 200; k++) begin
            @(negedge clock);
            if (bus.done != 0) n++;
            if (n == 4) break;
        end
        @(posedge clock); #1 bus.req = '0;
        check("rr_four_bursts", n, 4);
        check("rr_grant_0", gq[g0], 0);
        check("rr_grant_1", gq[g0+1], 1);
        check("rr_grant_2", gq[g0+2], 2);
        check("rr_grant_3", gq[g0+3], 0);
        check("rr_done_0", done_cnt[0] - dd[0], 2);
        check("rr_done_1", done_cnt[1] - dd[1], 1);
        check("rr_done_2", done_cnt[2] - dd[2], 1);
        check("idle_gap", bad_gap, 0);

        // data_valid stall after the second data byte
        @(posedge clock); #1;
        s0 = sent.size(); a0 = ack_cnt[0]; i0 = idx[0];
        bus.len[8:0] = 9'd4; base_r[0] = 8'h30; bus.data_valid = '1; bus.req[0] = 1'b1;
        n = 0;
        for (k = 0; k < 100; k++) begin
            @(negedge clock);
            if (bus.data_ack[0]) n++;
            if (n == 2) break;
        end
        check("stall_reach_byte2", n, 2);
        @(posedge clock); #1 bus.data_valid[0] = 1'b0;
        st = 0;
        repeat (5) begin
            @(negedge clock);
            if (bus.spi_start !== 1'b0 || bus.data_ack[0] !== 1'b0) st++;
        end
        check("stall_start_low", st, 0);
        @(posedge clock); #1 bus.data_valid[0] = 1'b1;
        for (k = 0; k < 100; k++) begin
            @(negedge clock);
            if (bus.done[0]) break;
        end
        check("stall_done_seen", k < 100, 1);
        @(posedge clock); #1 bus.req[0] = 1'b0;
        check("stall_nbytes", sent.size() - s0, 6);
        bad = 0;
        for (int j = 0; j < 4; j++) begin
            exp = {1'b1, 8'h30 + i0 + 8'(j)};
            if (sent[s0+2+j] !== exp) bad++;
        end
        check("stall_data_bad", bad, 0);
        check("stall_acks", ack_cnt[0] - a0, 4);

        // Abort: requester 2 drops req while stalled in the data phase
        @(posedge clock); #1;
        s0 = sent.size(); d0 = done_cnt[2];
        bus.len[26:18] = 9'd3; bus.data_valid[2] = 1'b0; bus.req[2] = 1'b1;
        repeat (4) @(negedge clock);
        check("abort_grant_before", bus.grant, 3'b100);
        @(posedge clock); #1 bus.req[2] = 1'b0;
        repeat (2) @(negedge clock);
        check("abort_grant_dropped", bus.grant, 0);
        check("abort_no_done", done_cnt[2] - d0, 0);
        check("abort_nbytes", sent.size() - s0, 2);
        bus.data_valid = '1;

        // Reset during the second data byte of a five-byte burst
        @(posedge clock); #1;
        d0 = done_cnt[1];
        bus.len[17:9] = 9'd5; bus.req[1] = 1'b1;
        n = 0;
        for (k = 0; k < 100; k++) begin
            @(negedge clock);
            if (bus.data_ack[1]) n++;
            if (n == 2) break;
        end
        check("rst_reach_byte2", n, 2);
        Reset = 1'b0;
        @(negedge clock);
        check("rst_mid_outputs", outs(), 0);
        bus.req = '0;
        s1 = sent.size();
        @(posedge clock); #1 Reset = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge clock);
            if (sent.size() > s1) break;
        end
        check("reinit_started", sent.size() > s1, 1);
        check("reinit_first_byte", sent[s1], 9'h021);
        check("rst_no_done", done_cnt[1] - d0, 0);
        check("no_grant_before_init", bad_pre, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
